// File: rtl/ssd_scan_ctl.sv
// Four-digit 14-segment scan controller: walks one shared decoder across the
// digits, applies game-logic loads only at frame boundaries, blanks and blinks.
module ssd_scan_ctl #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [15:0] i_din,
  input  logic        i_blank_lz,
  input  logic [3:0]  i_blink_mask,
  output logic [3:0]  o_bcd,
  output logic [3:0]  o_ssd_ctl,
  output logic        o_ack,
  output logic        o_frame_tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BL_MAX  = BW'(BLINK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_slot;
  logic [15:0]   r_act_dig;
  logic          r_act_lz;
  logic [3:0]    r_act_mask;
  logic [15:0]   r_pend_dig;
  logic          r_pend_lz;
  logic [3:0]    r_pend_mask;
  logic          r_pend_v;
  logic [BW-1:0] r_bl_cnt;
  logic          r_bl_ph;

  logic          w_tick;
  logic          w_frame;
  logic          w_apply;
  logic [1:0]    w_slot_n;
  logic [15:0]   w_act_dig_n;
  logic          w_act_lz_n;
  logic [3:0]    w_act_mask_n;
  logic          w_bl_ph_n;
  logic          w_z3;
  logic          w_z2;
  logic          w_z1;
  logic          w_lz_hit;
  logic [3:0]    w_bcd_n;
  logic [3:0]    w_ctl_n;

  always_comb begin
    w_tick   = (r_cnt == CNT_MAX);
    w_frame  = w_tick && (r_slot == 2'd0);
    w_apply  = w_frame && (r_pend_v || i_load);
    w_slot_n = w_tick ? (r_slot - 2'd1) : r_slot;

    // A load landing on the boundary edge wins over the older pending copy.
    w_act_dig_n  = r_act_dig;
    w_act_lz_n   = r_act_lz;
    w_act_mask_n = r_act_mask;
    if (w_apply) begin
      if (i_load) begin
        w_act_dig_n  = i_din;
        w_act_lz_n   = i_blank_lz;
        w_act_mask_n = i_blink_mask;
      end else begin
        w_act_dig_n  = r_pend_dig;
        w_act_lz_n   = r_pend_lz;
        w_act_mask_n = r_pend_mask;
      end
    end

    w_bl_ph_n = r_bl_ph;
    if (w_frame && (r_bl_cnt == BL_MAX)) begin
      w_bl_ph_n = ~r_bl_ph;
    end

    w_z3 = (w_act_dig_n[15:12] == 4'd0);
    w_z2 = w_z3 && (w_act_dig_n[11:8] == 4'd0);
    w_z1 = w_z2 && (w_act_dig_n[7:4] == 4'd0);

    unique case (w_slot_n)
      2'd3:    w_lz_hit = w_z3;
      2'd2:    w_lz_hit = w_z2;
      2'd1:    w_lz_hit = w_z1;
      default: w_lz_hit = 1'b0;
    endcase

    w_bcd_n = w_act_dig_n[{w_slot_n, 2'b00} +: 4];
    if (w_act_lz_n && w_lz_hit) begin
      w_bcd_n = 4'hF;
    end
    if (w_bl_ph_n && w_act_mask_n[w_slot_n]) begin
      w_bcd_n = 4'hF;
    end

    w_ctl_n = ~(4'b0001 << w_slot_n);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_slot       <= 2'd3;
      r_act_dig    <= '1;
      r_act_lz     <= 1'b0;
      r_act_mask   <= '0;
      r_pend_dig   <= '1;
      r_pend_lz    <= 1'b0;
      r_pend_mask  <= '0;
      r_pend_v     <= 1'b0;
      r_bl_cnt     <= '0;
      r_bl_ph      <= 1'b0;
      o_bcd        <= 4'hF;
      o_ssd_ctl    <= 4'b0111;
      o_ack        <= 1'b0;
      o_frame_tick <= 1'b0;
    end else begin
      r_cnt      <= w_tick ? '0 : r_cnt + 1'b1;
      r_slot     <= w_slot_n;
      r_act_dig  <= w_act_dig_n;
      r_act_lz   <= w_act_lz_n;
      r_act_mask <= w_act_mask_n;

      if (i_load && !w_apply) begin
        r_pend_dig  <= i_din;
        r_pend_lz   <= i_blank_lz;
        r_pend_mask <= i_blink_mask;
        r_pend_v    <= 1'b1;
      end else if (w_apply) begin
        r_pend_v <= 1'b0;
      end

      if (w_frame) begin
        r_bl_cnt <= (r_bl_cnt == BL_MAX) ? '0 : r_bl_cnt + 1'b1;
      end
      r_bl_ph <= w_bl_ph_n;

      o_bcd        <= w_bcd_n;
      o_ssd_ctl    <= w_ctl_n;
      o_ack        <= w_apply;
      o_frame_tick <= w_frame;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Scoreboard bench for ssd_scan_ctl with SCAN_DIV=4, BLINK_DIV=2: expected
// per-slot outputs are queued with the stimulus and popped as slots go by.
module tb_ssd_scan_ctl;

  localparam int unsigned SD = 4;
  localparam int unsigned BD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] din = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  bcd;
  logic [3:0]  ssd_ctl;
  logic        ack;
  logic        frame_tick;

  ssd_scan_ctl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load      (load),
    .i_din       (din),
    .i_blank_lz  (blank_lz),
    .i_blink_mask(blink_mask),
    .o_bcd       (bcd),
    .o_ssd_ctl   (ssd_ctl),
    .o_ack       (ack),
    .o_frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] sid;
    logic [3:0] bcd;
    logic [3:0] ctl;
    logic       ack;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Edges since the reset edge; output after edge n is sampled at the following negedge.
  always @(posedge clk) begin
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
  end

  task automatic push_frame(input logic [7:0] sid, input logic [15:0] codes,
                            input logic a, input logic f);
    exp_t e;
    logic [3:0] ctl_tab [4];
    ctl_tab[3] = 4'b0111;
    ctl_tab[2] = 4'b1011;
    ctl_tab[1] = 4'b1101;
    ctl_tab[0] = 4'b1110;
    for (int s = 3; s >= 0; s--) begin
      e.sid = sid;
      e.bcd = codes[4*s +: 4];
      e.ctl = ctl_tab[s];
      e.ack = (s == 3) ? a : 1'b0;
      e.ft  = (s == 3) ? f : 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic goto(input int c);
    for (int k = 0; k < 4096 && cyc < c; k++) begin
      @(posedge clk); #1;
    end
    if (cyc != c) check("goto_timeout", cyc, c);
  endtask

  task automatic do_reset(input logic [7:0] sid, input bit chk_empty);
    if (chk_empty) check($sformatf("s%0d_sb_drain", sid), q.size(), 0);
    mon_en = 1'b0;
    q.delete();
    load = 1'b0;
    rst  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    push_frame(sid, 16'hFFFF, 1'b0, 1'b0);
    mon_en = 1'b1;
  endtask

  task automatic do_load(input int c, input logic [15:0] d, input logic lz, input logic [3:0] m);
    goto(c - 1);
    load       = 1'b1;
    din        = d;
    blank_lz   = lz;
    blink_mask = m;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  initial begin : monitor
    exp_t cur;
    bit   have;
    bit   first;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        first = (cyc % SD == 0);
        if (first) begin
          if (q.size() == 0) begin
            check($sformatf("sb_underflow_n%0d", cyc), q.size(), 1);
            have = 1'b0;
          end else begin
            cur  = q.pop_front();
            have = 1'b1;
          end
        end
        if (have) begin
          check($sformatf("s%0d_n%0d_bcd", cur.sid, cyc), bcd, cur.bcd);
          check($sformatf("s%0d_n%0d_ctl", cur.sid, cyc), ssd_ctl, cur.ctl);
          check($sformatf("s%0d_n%0d_ack", cur.sid, cyc), ack, first ? cur.ack : 1'b0);
          check($sformatf("s%0d_n%0d_ftick", cur.sid, cyc), frame_tick, first ? cur.ft : 1'b0);
        end
      end else begin
        have = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1);
  end

  initial begin : stimulus
    logic [15:0] blink_val;

    // 1: reset and idle
    do_reset(8'd1, 1'b0);
    push_frame(8'd1, 16'hFFFF, 1'b0, 1'b1);
    push_frame(8'd1, 16'hFFFF, 1'b0, 1'b1);
    goto(48);

    // 2: basic load
    do_reset(8'd2, 1'b1);
    do_load(2, 16'h1234, 1'b0, 4'b0000);
    push_frame(8'd2, 16'h1234, 1'b1, 1'b1);
    push_frame(8'd2, 16'h1234, 1'b0, 1'b1);
    goto(48);

    // 3: leading-zero blanking
    do_reset(8'd3, 1'b1);
    do_load(2, 16'h0007, 1'b1, 4'b0000);
    push_frame(8'd3, 16'hFFF7, 1'b1, 1'b1);
    do_load(18, 16'h0000, 1'b1, 4'b0000);
    push_frame(8'd3, 16'hFFF0, 1'b1, 1'b1);
    do_load(34, 16'h0102, 1'b1, 4'b0000);
    push_frame(8'd3, 16'hF102, 1'b1, 1'b1);
    do_load(50, 16'h0007, 1'b0, 4'b0000);
    push_frame(8'd3, 16'h0007, 1'b1, 1'b1);
    goto(80);

    // 4: blink on digit 0; phase counts frames since reset
    do_reset(8'd4, 1'b1);
    do_load(2, 16'h5678, 1'b0, 4'b0001);
    for (int k = 1; k <= 6; k++) begin
      blink_val = (((k / BD) % 2) == 1) ? 16'h567F : 16'h5678;
      push_frame(8'd4, blink_val, (k == 1), 1'b1);
    end
    goto(112);

    // 5: two loads in one frame, only the latest shows, one ack
    do_reset(8'd5, 1'b1);
    do_load(2, 16'h1111, 1'b0, 4'b0000);
    do_load(9, 16'h2222, 1'b0, 4'b0000);
    push_frame(8'd5, 16'h2222, 1'b1, 1'b1);
    push_frame(8'd5, 16'h2222, 1'b0, 1'b1);
    goto(48);

    // 6: load on the boundary edge, then boundary load overriding a pending one
    do_reset(8'd6, 1'b1);
    do_load(16, 16'h3333, 1'b0, 4'b0000);
    push_frame(8'd6, 16'h3333, 1'b1, 1'b1);
    do_load(20, 16'h1111, 1'b0, 4'b0000);
    do_load(32, 16'h4444, 1'b0, 4'b0000);
    push_frame(8'd6, 16'h4444, 1'b1, 1'b1);
    goto(48);

    // 7: reset mid-slot discards a pending load
    do_reset(8'd7, 1'b1);
    do_load(2, 16'h7777, 1'b0, 4'b0000);
    goto(9);
    do_reset(8'd7, 1'b0);
    push_frame(8'd7, 16'hFFFF, 1'b0, 1'b1);
    push_frame(8'd7, 16'hFFFF, 1'b0, 1'b1);
    goto(48);
    check("s7_sb_drain", q.size(), 0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctl.md
# ssd_scan_ctl

Time-multiplexed scan controller for the four-digit 14-segment display. It holds four BCD digit values and walks one shared `ssd_decoder` instance across the digits, one slot at a time. The decoder's input is driven on `bcd` and the matching active-low digit enable on `ssd_ctl`. Game logic writes new scores and timers through a load/ack handshake, and the controller applies them only at frame boundaries so a frame never shows a mix of old and new digits. It also provides leading-zero blanking and per-digit blinking by substituting code 15 (blank) into the decoder.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit slot, ≥2.
- `BLINK_DIV`, default 64: frames per blink half-period, ≥1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `load`  in  1  one-cycle request to capture `din`, `blank_lz`, `blink_mask`.
- `din`  in  16  four BCD nibbles; `din[15:12]` = digit 3 (leftmost), `din[3:0]` = digit 0.
- `blank_lz`  in  1  leading-zero blanking enable, captured with `load`.
- `blink_mask`  in  4  per-digit blink enable (bit n = digit n), captured with `load`.
- `bcd`  out  4  code to `ssd_decoder`, registered.
- `ssd_ctl`  out  4  active-low one-hot digit enable (bit n = digit n), registered.
- `ack`  out  1  one-cycle pulse when a captured load becomes active.
- `frame_tick`  out  1  one-cycle pulse at start of each frame.

## Operation
- Registers:
  - `cnt`: prescaler, 0..SCAN_DIV-1, wraps.
  - `slot`: 2 bits.
  - `act_*`: active digits, lz flag and mask.
  - `pend_*`: pending copy of the same fields, plus `pend_v`.
  - `bl_cnt`: 0..BLINK_DIV-1.
  - `bl_ph`: blink phase.
- Tick: the edge where `cnt == SCAN_DIV-1`. On a tick, `slot` steps 3→2→1→0→3.
- Frame boundary: a tick with `slot == 0`, i.e. the edge where the frame restarts at slot 3.
- Load capture: `load` high copies the inputs into `pend_*` and sets `pend_v`. A second load before the boundary overwrites the pending copy; only the latest is applied and only one `ack` is issued.
- Frame boundary with `pend_v` or `load` high:
  - `act_*` takes the pending value; a `load` on that same edge takes priority and its inputs bypass directly to `act_*`.
  - `pend_v` clears.
  - `ack` pulses.
- Leading-zero blanking (when act lz = 1):
  - Digit n (n = 3, 2, 1) shows 15 if its value is 0 and every higher digit is 0.
  - Digit 0 is never blanked.
  - Only value 0 counts as a zero; codes 10–15 pass through unchanged.
- Blink:
  - `bl_cnt` increments on each frame boundary. At wrap, `bl_ph` toggles.
  - While `bl_ph == 1`, each digit whose mask bit is set shows 15.
  - `ssd_ctl` scanning is unaffected by blinking.
- Output formation: `bcd`/`ssd_ctl` are computed from the next-state `slot` and next-state `act_*`, then registered. The first slot-3 cycle of a frame therefore already shows newly applied data.
- Reset value of every register and output:
  - `cnt` = 0, `slot` = 3.
  - `act` digits = 16'hFFFF, lz = 0, mask = 0.
  - `pend_v` = 0.
  - `bl_cnt` = 0, `bl_ph` = 0.
  - `bcd` = 4'hF, `ssd_ctl` = 4'b0111.
  - `ack` = 0, `frame_tick` = 0.
- `rst` has priority over everything and discards any pending load.

## Timing
- The outputs `bcd` and `ssd_ctl` each change only on tick edges (and on reset). They hold for exactly SCAN_DIV cycles per slot, and a frame lasts 4·SCAN_DIV cycles.
- `frame_tick` and `ack` are high for exactly the first cycle of slot 3. `ack` occurs only in frames that applied a load.
- Load-to-display latency: from 1 cycle (load on the boundary edge) up to 4·SCAN_DIV cycles.
- First frame boundary after reset release: edge 4·SCAN_DIV, counting the first post-reset edge as 1.
- Blink half-period: BLINK_DIV frames.
- `rst` asserted mid-slot: reset values appear after the next edge, and counting restarts from `cnt` = 0.

## Test plan
All scenarios use SCAN_DIV = 4 and BLINK_DIV = 2.
- Reset and idle: release reset → `ssd_ctl` = 0111 and `bcd` = F; after 4 cycles `ssd_ctl` = 1011, `bcd` = F; the sequence repeats with period 16; `ack` = 0 throughout.
- Basic load: `load` with `din` = 16'h1234 at cycle 2 → at cycle 16 `ack` = `frame_tick` = 1, `ssd_ctl` = 0111, `bcd` = 1; then `bcd` = 2, 3, 4 every 4 cycles with `ssd_ctl` 1011, 1101, 1110.
- Leading-zero blanking, with `blank_lz` = 1:
  - 16'h0007 → F, F, F, 7.
  - 16'h0000 → F, F, F, 0.
  - 16'h0102 → F, 1, 0, 2.
  - With `blank_lz` = 0, 16'h0007 → 0, 0, 0, 7.
- Blink: `din` = 16'h5678, `blink_mask` = 0001 → digit 0 shows 8 for 2 frames, then F for 2 frames, repeating; digits 3–1 stay 5, 6, 7.
- Load collisions:
  - Loads of 16'h1111 then 16'h2222 within one frame → a single `ack`; 2222 is displayed.
  - A load of 16'h3333 on the boundary edge → `bcd` = 3 in the next cycle, and `ack` is high in that cycle.
- Reset mid-operation: a load is pending, then `rst` is asserted at cycle 10 → the next cycle shows `bcd` = F and `ssd_ctl` = 0111; no `ack` follows and the display stays blank.
